vec_feeder: RTL and testbench

VEC_FEEDER -- requirements
Module: vec_feeder

---
 rtl/vec_feeder.sv | 119 +++++++++++
 tb/tb_vec_feeder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_feeder.sv
// vec_feeder: loads an element-pair stream into packed x/k vectors, runs an external MAC with timeout, returns one result per frame.
module vec_feeder #(
    parameter int C   = 8,
    parameter int W_X = 8,
    parameter int W_K = 8,
    parameter int TMO = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [W_X-1:0]         s_x,
    input  logic [W_K-1:0]         s_k,
    input  logic                   s_last,
    output logic [C*W_X-1:0]       x,
    output logic [C*W_K-1:0]       k,
    output logic                   mac_en,
    input  logic                   mac_valid,
    input  logic [W_X-1:0]         mac_y,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [W_X-1:0]         m_y,
    output logic                   m_err,
    output logic [$clog2(C):0]     m_len
);
    localparam int CW = $clog2(C);
    localparam int TW = $clog2(TMO);
    localparam int LW = CW + 1;

    typedef enum logic [1:0] {LOAD, RUN, OUT} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [TW-1:0]    tcnt_q, tcnt_d;
    logic [C*W_X-1:0] x_q, x_d;
    logic [C*W_K-1:0] k_q, k_d;
    logic [W_X-1:0]   m_y_q, m_y_d;
    logic             m_err_q, m_err_d;
    logic [LW-1:0]    m_len_q, m_len_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tcnt_d  = tcnt_q;
        x_d     = x_q;
        k_d     = k_q;
        m_y_d   = m_y_q;
        m_err_d = m_err_q;
        m_len_d = m_len_q;
        case (state_q)
            LOAD: if (s_valid) begin
                x_d[cnt_q*W_X +: W_X] = s_x;
                k_d[cnt_q*W_K +: W_K] = s_k;
                if (s_last || cnt_q == CW'(C-1)) begin
                    state_d = RUN;
                    tcnt_d  = '0;
                    m_len_d = LW'(cnt_q) + LW'(1);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RUN: begin
                tcnt_d = tcnt_q + TW'(1);
                // a result arriving on the last allowed cycle wins over the timeout
                if (mac_valid) begin
                    m_y_d   = mac_y;
                    m_err_d = 1'b0;
                    state_d = OUT;
                end else if (tcnt_q == TW'(TMO-1)) begin
                    m_y_d   = '0;
                    m_err_d = 1'b1;
                    state_d = OUT;
                end
            end
            OUT: if (m_ready) begin
                state_d = LOAD;
                cnt_d   = '0;
                tcnt_d  = '0;
                x_d     = '0;
                k_d     = '0;
                m_y_d   = '0;
                m_err_d = 1'b0;
                m_len_d = '0;
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LOAD;
            cnt_q   <= '0;
            tcnt_q  <= '0;
            x_q     <= '0;
            k_q     <= '0;
            m_y_q   <= '0;
            m_err_q <= 1'b0;
            m_len_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tcnt_q  <= tcnt_d;
            x_q     <= x_d;
            k_q     <= k_d;
            m_y_q   <= m_y_d;
            m_err_q <= m_err_d;
            m_len_q <= m_len_d;
        end
    end

    assign s_ready = state_q == LOAD;
    assign mac_en  = state_q == RUN;
    assign m_valid = state_q == OUT;
    assign x       = x_q;
    assign k       = k_q;
    assign m_y     = m_y_q;
    assign m_err   = m_err_q;
    assign m_len   = m_len_q;
endmodule

// File: tb/tb_vec_feeder.sv
// tb_vec_feeder: directed table frames, multi-cycle corner sequences and 1000 random frames against a dot-product reference.
module tb_vec_feeder;
    localparam int C = 8, W_X = 8, W_K = 8, TMO = 64, LW = $clog2(C) + 1;

    logic clk = 1'b0, rst, s_valid, s_ready, s_last, mac_en, mac_valid, m_valid, m_ready, m_err;
    logic [W_X-1:0] s_x, mac_y, m_y;
    logic [W_K-1:0] s_k;
    logic [C*W_X-1:0] x;
    logic [C*W_K-1:0] k;
    logic [LW-1:0] m_len;

    int vectors = 0, miscompares = 0;
    bit mac_on = 1'b1;
    int mac_lat = 0;
    logic signed [7:0] fx[C], fk[C];

    typedef struct {
        int         len;
        bit         use_last;
        logic [63:0] xs;
        logic [63:0] ks;
        logic [7:0]  exp_y;
    } vec_t;
    vec_t tbl[6];

    always #5 clk = ~clk;

    vec_feeder #(.C(C), .W_X(W_X), .W_K(W_K), .TMO(TMO)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_x(s_x), .s_k(s_k),
        .s_last(s_last), .x(x), .k(k), .mac_en(mac_en), .mac_valid(mac_valid), .mac_y(mac_y),
        .m_valid(m_valid), .m_ready(m_ready), .m_y(m_y), .m_err(m_err), .m_len(m_len)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ref_dot(input int len);
        int s = 0;
        for (int i = 0; i < len; i++) s += int'(fx[i]) * int'(fk[i]);
        return s[7:0];
    endfunction

    function automatic logic [63:0] exp_vec(input int len, input bit is_k);
        logic [63:0] v = '0;
        for (int i = 0; i < len; i++) v[i*8 +: 8] = is_k ? fk[i] : fx[i];
        return v;
    endfunction

    // MAC model: multiplies whatever vector the feeder presents, after mac_lat cycles of mac_en
    function automatic logic [7:0] mac_dot();
        int s = 0;
        for (int i = 0; i < C; i++) s += int'($signed(x[i*8 +: 8])) * int'($signed(k[i*8 +: 8]));
        return s[7:0];
    endfunction

    initial begin
        int lc = -1;
        mac_valid = 1'b0;
        mac_y = '0;
        forever begin
            tick();
            mac_valid = 1'b0;
            if (rst || !mac_en) lc = -1;
            else begin
                if (lc == -1) lc = mac_lat;
                if (lc == 0 && mac_on) begin
                    mac_valid = 1'b1;
                    mac_y = mac_dot();
                    lc = -2;
                end else if (lc > 0) lc--;
            end
        end
    end

    task automatic send_pair(input logic [7:0] xv, input logic [7:0] kv, input bit last, input int gap);
        bit ok = 1'b0;
        s_valid = 1'b0;
        repeat (gap) tick();
        s_x = xv;
        s_k = kv;
        s_last = last;
        s_valid = 1'b1;
        for (int n = 0; n < 50 && !ok; n++) begin
            ok = s_ready;
            tick();
        end
        if (!ok) chk("accept_timeout", 0, 1);
        s_valid = 1'b0;
        s_last = 1'b0;
    endtask

    task automatic get_result(input string tag, input logic [7:0] exp_y, input int exp_len, input bit exp_err, input int hold);
        int n = 0;
        logic [7:0] y0;
        m_ready = 1'b0;
        while (!m_valid && n < 300) begin
            tick();
            n++;
        end
        if (!m_valid) begin
            chk({tag, "_mvalid_timeout"}, 0, 1);
            return;
        end
        chk({tag, "_m_y"}, m_y, exp_y);
        chk({tag, "_m_len"}, m_len, exp_len);
        chk({tag, "_m_err"}, m_err, exp_err);
        chk({tag, "_x"}, x, exp_vec(exp_len, 1'b0));
        chk({tag, "_k"}, k, exp_vec(exp_len, 1'b1));
        y0 = m_y;
        for (int i = 0; i < hold; i++) begin
            tick();
            chk({tag, "_hold_valid"}, m_valid, 1);
            chk({tag, "_hold_y"}, m_y, y0);
            chk({tag, "_hold_sready"}, s_ready, 0);
            chk({tag, "_hold_macen"}, mac_en, 0);
        end
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk({tag, "_exit_valid"}, m_valid, 0);
        chk({tag, "_exit_sready"}, s_ready, 1);
        chk({tag, "_exit_x"}, x, 0);
    endtask

    task automatic run_frame(input string tag, input int len, input bit use_last, input logic [7:0] exp_y,
                             input int gapmax, input int hold);
        for (int i = 0; i < len; i++)
            send_pair(fx[i], fk[i], use_last && i == len - 1, $urandom_range(0, gapmax));
        get_result(tag, exp_y, len, 1'b0, hold);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_macen"}, mac_en, 0);
        chk({tag, "_mvalid"}, m_valid, 0);
        chk({tag, "_m_y"}, m_y, 0);
        chk({tag, "_m_err"}, m_err, 0);
        chk({tag, "_m_len"}, m_len, 0);
        chk({tag, "_x"}, x, 0);
        chk({tag, "_k"}, k, 0);
    endtask

    initial begin
        int en_cnt, n, mv_cnt, len;
        bit ul;
        tbl[0] = '{8, 1'b1, {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, {8{8'd2}}, 8'd72};
        tbl[1] = '{3, 1'b1, {40'd0, 8'd5, 8'd4, 8'hFD}, {40'd0, 8'd2, 8'hFF, 8'd7}, 8'hF1};
        tbl[2] = '{1, 1'b1, {56'd0, 8'h80}, {56'd0, 8'd1}, 8'h80};
        tbl[3] = '{8, 1'b0, {8{8'd127}}, {8{8'd127}}, 8'd8};
        tbl[4] = '{2, 1'b1, {48'd0, 8'hFF, 8'hFF}, {48'd0, 8'hFF, 8'hFF}, 8'd2};
        tbl[5] = '{8, 1'b1, {8{8'h80}}, {8{8'h80}}, 8'd0};

        rst = 1'b1; s_valid = 1'b0; s_x = '0; s_k = '0; s_last = 1'b0; m_ready = 1'b0;
        repeat (3) tick();
        chk_zero("reset");
        rst = 1'b0;
        tick();
        chk("reset_release_sready", s_ready, 1);

        mac_lat = 2;
        foreach (tbl[t]) begin
            for (int i = 0; i < C; i++) begin
                fx[i] = tbl[t].xs[i*8 +: 8];
                fk[i] = tbl[t].ks[i*8 +: 8];
            end
            run_frame($sformatf("tbl%0d", t), tbl[t].len, tbl[t].use_last, tbl[t].exp_y, 0, 0);
        end

        // result held for 10 cycles with the consumer stalled
        for (int i = 0; i < C; i++) begin fx[i] = 8'($urandom); fk[i] = 8'($urandom); end
        for (int i = 4; i < C; i++) begin fx[i] = 0; fk[i] = 0; end
        run_frame("stall", 4, 1'b1, ref_dot(4), 1, 10);

        // timeout: MAC never answers
        mac_on = 1'b0;
        for (int i = 0; i < C; i++) begin fx[i] = 8'(i + 1); fk[i] = 8'd3; end
        for (int i = 0; i < C; i++) send_pair(fx[i], fk[i], 1'b0, 0);
        en_cnt = 0;
        n = 0;
        while (!m_valid && n < 300) begin
            if (mac_en) en_cnt++;
            tick();
            n++;
        end
        chk("tmo_run_cycles", en_cnt, TMO);
        chk("tmo_macen_low", mac_en, 0);
        get_result("tmo", 8'd0, C, 1'b1, 0);

        // reset mid-LOAD
        for (int i = 0; i < 5; i++) send_pair(8'(i + 9), 8'd1, 1'b0, 0);
        rst = 1'b1;
        #1;
        chk_zero("rst_load");
        tick();
        rst = 1'b0;
        tick();
        chk("rst_load_sready", s_ready, 1);

        // reset mid-RUN
        for (int i = 0; i < C; i++) send_pair(8'd5, 8'd5, 1'b0, 0);
        repeat (3) tick();
        chk("pre_rst_run_macen", mac_en, 1);
        rst = 1'b1;
        #1;
        chk_zero("rst_run");
        tick();
        rst = 1'b0;
        mv_cnt = 0;
        repeat (80) begin
            tick();
            if (m_valid) mv_cnt++;
        end
        chk("rst_run_no_mvalid", mv_cnt, 0);
        mac_on = 1'b1;
        for (int i = 0; i < C; i++) begin fx[i] = 8'($urandom); fk[i] = 8'($urandom); end
        run_frame("post_rst", C, 1'b1, ref_dot(C), 0, 0);

        for (int f = 0; f < 1000; f++) begin
            len = $urandom_range(1, C);
            ul = (len < C) ? 1'b1 : 1'($urandom);
            for (int i = 0; i < C; i++) begin
                fx[i] = (i < len) ? 8'($urandom) : 8'd0;
                fk[i] = (i < len) ? 8'($urandom) : 8'd0;
            end
            mac_lat = $urandom_range(0, 5);
            run_frame($sformatf("rnd%0d", f), len, ul, ref_dot(len), 2, $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
